blade_env_responder: RTL
========================

// Module: blade_env_responder
// PURPOSE
//  Clocked responder for the right-side and error-detect handshakes of the async pipeline controller.
//  It acknowledges Rreq and LEreq, and answers each sample pulse with a dual-rail Err1/Err0 verdict.
//  This is the synthesizable replacement for the behavioural bench environment, for FPGA bring-up and on-chip test.
//  All request inputs are asynchronous to clk and pass through 2-flop synchronizers.
// PARAMETERS
//  ACK_DELAY  4   cycles inserted between a synced Rreq edge and the matching Rack edge (0..255)
//  ERR_DELAY  2   cycles between synced sample rise and Err verdict (0..255)
//  CNT_W      16  width of token_count
// PORTS
//  clk          in   1      responder clock
//  rst_n        in   1      asynchronous active-low reset
//  Rreq         in   1      right request from controller (async, 4-phase)
//  Rack         out  1      right acknowledge
//  LEreq        in   1      error-latch request from controller (async, 4-phase)
//  LEack        out  1      error-latch acknowledge
//  sample       in   1      error-sample strobe from controller (async)
//  err_inject   in   1      sync; 1 = report error on next sample
//  Err1         out  1      dual-rail error-detected rail
//  Err0         out  1      dual-rail no-error rail
//  token_count  out  CNT_W  completed right-side handshakes, wraps
//  protocol_err out  1      sticky: Rreq withdrawn before Rack
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - All outputs are 0: Rack, LEack, Err1, Err0, token_count, protocol_err.
//   - Synchronizers clear; R FSM goes to IDLE.
//   - Deassertion is synchronous to clk (2-flop reset release).
//  Synchronizers: rreq_s, lereq_s and sample_s are the second-flop outputs. Use only these internally.
//  R FSM (4-phase, return-to-zero):
//   - IDLE: Rack=0. When rreq_s=1, load dly=ACK_DELAY and go to ACK_WAIT.
//   - ACK_WAIT: dly decrements each cycle. At dly==0, set Rack=1, increment token_count (mod 2^CNT_W), go to ACKED.
//   - ACKED: Rack=1. When rreq_s=0, load dly=ACK_DELAY and go to REL_WAIT.
//   - REL_WAIT: dly decrements. At dly==0, set Rack=0 and go to IDLE.
//   - Latency: async Rreq edge to Rack edge = ACK_DELAY+3 clk edges (2 sync + ACK_DELAY + 1 register).
//   - ACK_DELAY=0 is legal; latency is then 3 edges.
//   - rreq_s=0 seen in ACK_WAIT sets protocol_err. The FSM still completes ACKED then REL_WAIT; no hang.
//   - protocol_err clears only on reset.
//   - token_count wraps from 2^CNT_W-1 to 0 with no flag.
//  LE channel: LEack = lereq_s delayed one register, i.e. 3 edges after an LEreq edge. It is independent of the R FSM.
//  Error channel:
//   - On a sample_s rising edge, capture err_inject into err_q and load edly=ERR_DELAY.
//   - At edly==0: Err1=err_q, Err0=~err_q.
//   - On a sample_s falling edge: Err1=Err0=0 on the next edge (spacer).
//   - A fall that arrives before the verdict cancels the pending verdict; no verdict is issued.
//   - Err1 and Err0 are never 1 together. They are only non-zero while sample_s=1.
//   - err_inject changing while a verdict is pending has no effect; only the captured value counts.
//  Simultaneous events: R, LE and error channels are fully independent. Any combination may be active in one cycle.
//  Reset mid-handshake: all outputs drop to 0 immediately. After release the FSM starts in IDLE.
//   - If Rreq is still 1 after release, a new ACK_WAIT begins and token_count counts it again.
// TESTING
//  1. Defaults, Rreq 0->1 -> Rack rises exactly 7 edges later; token_count=1.
//     Then Rreq 1->0 -> Rack falls 7 edges later.
//  2. 70000 back-to-back Rreq handshakes, CNT_W=16 -> token_count wraps to 4464; protocol_err=0 throughout.
//  3. err_inject=1, sample 0->1 -> Err1=1, Err0=0 at edge 2+ERR_DELAY+1=5.
//     sample 1->0 -> both rails 0 within 3 edges. Repeat with err_inject=0 -> Err0=1.
//  4. Rreq pulse of 3 cycles, ACK_DELAY=10 -> protocol_err=1 (sticky).
//     Rack still completes a 1->0 cycle; the next handshake behaves normally.
//  5. rst_n pulled low while Rack=1 and Err1=1 -> all outputs 0 immediately with no clk edge.
//     Release with Rreq=1 -> Rack re-rises 7 edges after release.
//  6. LEreq toggled during an R ACK_WAIT and a sample pulse -> LEack follows at 3 edges.
//     Rack timing and Err verdict unchanged.

Source files
------------

// File: rtl/blade_env_responder.sv
// blade_env_responder
//   Clocked responder for the right-side and error-detect handshakes of the async pipeline
//   controller. Acknowledges Rreq (4-phase, programmable delay) and LEreq (pure delay), and
//   answers each sample pulse with a dual-rail Err1/Err0 verdict.
// Ports
//   clk           responder clock
//   rst_n         asynchronous active-low reset (assert async, release synchronised)
//   Rreq / Rack   right request (async) / acknowledge
//   LEreq / LEack error-latch request (async) / acknowledge
//   sample        error-sample strobe (async)
//   err_inject    synchronous; 1 = report an error on the next sample
//   Err1 / Err0   dual-rail verdict (error / no error), spacer = both 0
//   token_count   completed right-side handshakes, wraps silently
//   protocol_err  sticky: Rreq withdrawn before Rack
module blade_env_responder #(
  parameter int unsigned ACK_DELAY = 4,
  parameter int unsigned ERR_DELAY = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Rreq,
  output logic             Rack,
  input  logic             LEreq,
  output logic             LEack,
  input  logic             sample,
  input  logic             err_inject,
  output logic             Err1,
  output logic             Err0,
  output logic [CNT_W-1:0] token_count,
  output logic             protocol_err
);

  // Counters hold "remaining waits - 1" so a load of 0 fires on the very next edge, giving
  // ACK_DELAY+3 / ERR_DELAY+3 edges end to end. A delay of 0 bypasses the wait state.
  localparam logic [7:0] AckLoad = (ACK_DELAY == 0) ? 8'd0 : 8'(ACK_DELAY - 1);
  localparam logic [7:0] ErrLoad = (ERR_DELAY == 0) ? 8'd0 : 8'(ERR_DELAY - 1);

  typedef enum logic [1:0] {StIdle, StAckWait, StAcked, StRelWait} r_state_e;

  // Reset: asserted asynchronously, released two clk edges after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Input synchronisers run on the raw reset so they are already filled when the core leaves
  // reset; their own inputs are asynchronous anyway.
  logic [2:0] meta_q, sync_q;
  logic       rreq_s, lereq_s, sample_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {Rreq, LEreq, sample};
      sync_q <= meta_q;
    end
  end
  assign {rreq_s, lereq_s, sample_s} = sync_q;

  // R channel
  r_state_e   state_q, state_d;
  logic [7:0] dly_q, dly_d;
  logic       rack_q, rack_d;
  logic       perr_q, perr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rack_d  = rack_q;
    perr_d  = perr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rreq_s) begin
          if (ACK_DELAY == 0) begin
            rack_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StAcked;
          end else begin
            dly_d   = AckLoad;
            state_d = StAckWait;
          end
        end
      end
      StAckWait: begin
        if (!rreq_s) perr_d = 1'b1;  // withdrawn early; handshake still completes
        if (dly_q == 8'd0) begin
          rack_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StAcked;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      StAcked: begin
        if (!rreq_s) begin
          if (ACK_DELAY == 0) begin
            rack_d  = 1'b0;
            state_d = StIdle;
          end else begin
            dly_d   = AckLoad;
            state_d = StRelWait;
          end
        end
      end
      StRelWait: begin
        if (dly_q == 8'd0) begin
          rack_d  = 1'b0;
          state_d = StIdle;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Error channel
  logic       sample_prev_q;
  logic       pend_q, pend_d;
  logic [7:0] edly_q, edly_d;
  logic       err_q, err_d;
  logic       err1_q, err1_d, err0_q, err0_d;

  always_comb begin
    pend_d = pend_q;
    edly_d = edly_q;
    err_d  = err_q;
    err1_d = err1_q;
    err0_d = err0_q;
    if (!sample_s) begin
      // Spacer; also cancels a verdict still counting down.
      err1_d = 1'b0;
      err0_d = 1'b0;
      pend_d = 1'b0;
    end else if (!sample_prev_q) begin
      err_d = err_inject;
      if (ERR_DELAY == 0) begin
        err1_d = err_inject;
        err0_d = ~err_inject;
      end else begin
        edly_d = ErrLoad;
        pend_d = 1'b1;
      end
    end else if (pend_q) begin
      if (edly_q == 8'd0) begin
        err1_d = err_q;
        err0_d = ~err_q;
        pend_d = 1'b0;
      end else begin
        edly_d = edly_q - 8'd1;
      end
    end
  end

  // LE channel is a single register on the synchronised request.
  logic leack_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= StIdle;
      dly_q         <= 8'd0;
      rack_q        <= 1'b0;
      perr_q        <= 1'b0;
      cnt_q         <= '0;
      sample_prev_q <= 1'b0;
      pend_q        <= 1'b0;
      edly_q        <= 8'd0;
      err_q         <= 1'b0;
      err1_q        <= 1'b0;
      err0_q        <= 1'b0;
      leack_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      rack_q        <= rack_d;
      perr_q        <= perr_d;
      cnt_q         <= cnt_d;
      sample_prev_q <= sample_s;
      pend_q        <= pend_d;
      edly_q        <= edly_d;
      err_q         <= err_d;
      err1_q        <= err1_d;
      err0_q        <= err0_d;
      leack_q       <= lereq_s;
    end
  end

  assign Rack         = rack_q;
  assign LEack        = leack_q;
  assign Err1         = err1_q;
  assign Err0         = err0_q;
  assign token_count  = cnt_q;
  assign protocol_err = perr_q;

endmodule
